// File: rtl/xpu_pkg.sv
// Shared definitions for the xpu beacon path: scheduler state encoding,
// the TU-to-microsecond shift and the counter widths.
package xpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ALIGN  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_REQ    = 3'd3,
      ST_ACTIVE = 3'd4
   } sched_state_e;

   localparam int TU_SHIFT     = 10;
   localparam int DTIM_WIDTH   = 8;
   localparam int MISSED_WIDTH = 16;

   function automatic logic [MISSED_WIDTH-1:0] sat_inc(input logic [MISSED_WIDTH-1:0] v);
      logic [MISSED_WIDTH-1:0] r;
      if (v == {MISSED_WIDTH{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(MISSED_WIDTH-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/tsf_mod_serial.sv
// Restoring remainder of a wide dividend by a narrower divisor, one dividend
// bit per cycle; done pulses for one cycle after the last bit.
module tsf_mod_serial #(
   parameter int DVD_WIDTH = 64,
   parameter int DVS_WIDTH = 26
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 abort,
   input  logic [DVD_WIDTH-1:0] dividend,
   input  logic [DVS_WIDTH-1:0] divisor,
   output logic                 done,
   output logic [DVS_WIDTH-1:0] remainder
);

   localparam int CW = $clog2(DVD_WIDTH);

   logic [DVD_WIDTH-1:0] dvd_r;
   logic [DVS_WIDTH-1:0] dvs_r;
   logic [DVS_WIDTH-1:0] rem_r;
   logic [CW-1:0]        cnt_r;
   logic                 busy_r;
   logic                 done_r;

   logic [DVS_WIDTH:0]   trial_s;
   logic [DVS_WIDTH-1:0] diff_s;
   logic [DVS_WIDTH-1:0] rem_step_s;
   logic                 last_s;

   // One restoring step; the difference fits DVS_WIDTH bits whenever it is kept
   always_comb begin
      trial_s = {rem_r, dvd_r[DVD_WIDTH-1]};
      diff_s  = trial_s[DVS_WIDTH-1:0] - dvs_r;
      if (trial_s >= {1'b0, dvs_r}) begin
         rem_step_s = diff_s;
      end else begin
         rem_step_s = trial_s[DVS_WIDTH-1:0];
      end
      last_s = (cnt_r == CW'(DVD_WIDTH - 1));
   end

   // Iteration state; start overrides abort so a fresh run is never lost
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dvd_r  <= {DVD_WIDTH{1'b0}};
         dvs_r  <= {DVS_WIDTH{1'b0}};
         rem_r  <= {DVS_WIDTH{1'b0}};
         cnt_r  <= {CW{1'b0}};
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else if (start) begin
         dvd_r  <= dividend;
         dvs_r  <= divisor;
         rem_r  <= {DVS_WIDTH{1'b0}};
         cnt_r  <= {CW{1'b0}};
         busy_r <= 1'b1;
         done_r <= 1'b0;
      end else if (abort) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else if (busy_r) begin
         rem_r  <= rem_step_s;
         dvd_r  <= {dvd_r[DVD_WIDTH-2:0], 1'b0};
         cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
         busy_r <= !last_s;
         done_r <= last_s;
      end else begin
         done_r <= 1'b0;
      end
   end

   assign done      = done_r;
   assign remainder = rem_r;

endmodule

// File: rtl/beacon_tbtt_scheduler.sv
// Beacon TBTT scheduler: aligns TBTTs to the beacon interval on the TSF,
// requests the TX path ahead of each TBTT, tracks DTIM and missed beacons.
module beacon_tbtt_scheduler
   import xpu_pkg::*;
#(
   parameter int TIMER_WIDTH = 64,
   parameter int TU_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [TIMER_WIDTH-1:0]  tsf_runtime_val,
   input  logic                    start_beaconing,
   input  logic [TU_WIDTH-1:0]     beacon_interval_tu,
   input  logic [DTIM_WIDTH-1:0]   dtim_period,
   input  logic [15:0]             early_us,
   input  logic                    tx_ack,
   input  logic                    tx_done,
   output logic                    beacon_req,
   output logic                    beacon_is_dtim,
   output logic [DTIM_WIDTH-1:0]   dtim_count,
   output logic [TIMER_WIDTH-1:0]  next_tbtt,
   output logic                    tbtt_pulse,
   output logic [MISSED_WIDTH-1:0] missed_cnt
);

   localparam int IW = TU_WIDTH + TU_SHIFT;
   localparam int EW = TIMER_WIDTH + 1;

   logic [1:0]              rst_sync_r;
   logic                    rst_int_n;

   sched_state_e            state_r, state_nxt;
   logic [TIMER_WIDTH-1:0]  cap_r, cap_nxt;
   logic [IW-1:0]           interval_r, interval_nxt;
   logic [DTIM_WIDTH-1:0]   dtim_period_r, dtim_period_nxt;
   logic [TIMER_WIDTH-1:0]  next_tbtt_r, next_tbtt_nxt;
   logic [TIMER_WIDTH-1:0]  req_target_r, req_target_nxt;
   logic [DTIM_WIDTH-1:0]   dtim_count_r, dtim_count_nxt;
   logic [MISSED_WIDTH-1:0] missed_cnt_r, missed_nxt;
   logic                    beacon_req_r, req_nxt;
   logic                    beacon_is_dtim_r, is_dtim_nxt;
   logic                    tbtt_pulse_r, pulse_nxt;
   logic                    div_start_r, div_start_nxt;
   logic                    div_abort_s;
   logic                    div_done_s;
   logic [IW-1:0]           div_rem_s;
   logic                    tbtt_ev_s;

   logic [EW-1:0]           tsf_e, nt_e, iv_e, early_e, rt_e;
   logic                    fwd_s, bwd_s, early_hit_s, tbtt_hit_s, late_s;

   // Reset synchroniser: assertion is immediate, release follows two clocks
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end
   assign rst_int_n = rst_sync_r[1];

   tsf_mod_serial #(
      .DVD_WIDTH (TIMER_WIDTH),
      .DVS_WIDTH (IW)
   ) u_mod (
      .clk       (clk),
      .rstn      (rst_int_n),
      .start     (div_start_r),
      .abort     (div_abort_s),
      .dividend  (cap_r),
      .divisor   (interval_r),
      .done      (div_done_s),
      .remainder (div_rem_s)
   );

   // One extra bit keeps tsf+early and next_tbtt+interval from wrapping
   assign tsf_e   = {1'b0, tsf_runtime_val};
   assign nt_e    = {1'b0, next_tbtt_r};
   assign rt_e    = {1'b0, req_target_r};
   assign iv_e    = {{(EW-IW){1'b0}}, interval_r};
   assign early_e = {{(EW-16){1'b0}}, early_us};

   assign fwd_s       = tsf_e >= (nt_e + iv_e);
   assign bwd_s       = (nt_e > tsf_e) && ((nt_e - tsf_e) > iv_e);
   assign early_hit_s = (tsf_e + early_e) >= nt_e;
   assign tbtt_hit_s  = tsf_e >= nt_e;
   assign late_s      = tsf_e >= (rt_e + iv_e);

   // Next-state and next-register values
   always_comb begin
      state_nxt       = state_r;
      cap_nxt         = cap_r;
      interval_nxt    = interval_r;
      dtim_period_nxt = dtim_period_r;
      next_tbtt_nxt   = next_tbtt_r;
      req_target_nxt  = req_target_r;
      dtim_count_nxt  = dtim_count_r;
      missed_nxt      = missed_cnt_r;
      req_nxt         = beacon_req_r;
      is_dtim_nxt     = beacon_is_dtim_r;
      pulse_nxt       = 1'b0;
      div_start_nxt   = 1'b0;
      div_abort_s     = 1'b0;
      tbtt_ev_s       = 1'b0;

      if (!start_beaconing) begin
         state_nxt   = ST_IDLE;
         req_nxt     = 1'b0;
         div_abort_s = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (beacon_interval_tu != {TU_WIDTH{1'b0}}) begin
                  cap_nxt         = tsf_runtime_val;
                  interval_nxt    = {beacon_interval_tu, {TU_SHIFT{1'b0}}};
                  dtim_period_nxt = (dtim_period == 8'd0) ? 8'd1 : dtim_period;
                  div_start_nxt   = 1'b1;
                  state_nxt       = ST_ALIGN;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
            ST_ALIGN: begin
               // A done seen while the start is still in flight belongs to an older run
               if (div_done_s && !div_start_r) begin
                  next_tbtt_nxt  = cap_r - {{(TIMER_WIDTH-IW){1'b0}}, div_rem_s}
                                 + {{(TIMER_WIDTH-IW){1'b0}}, interval_r};
                  dtim_count_nxt = 8'd0;
                  state_nxt      = ST_WAIT;
               end else begin
                  state_nxt = ST_ALIGN;
               end
            end
            ST_WAIT: begin
               if (fwd_s) begin
                  missed_nxt    = sat_inc(missed_cnt_r);
                  cap_nxt       = tsf_runtime_val;
                  div_start_nxt = 1'b1;
                  state_nxt     = ST_ALIGN;
               end else if (bwd_s) begin
                  cap_nxt       = tsf_runtime_val;
                  div_start_nxt = 1'b1;
                  state_nxt     = ST_ALIGN;
               end else begin
                  tbtt_ev_s = tbtt_hit_s;
                  if (early_hit_s) begin
                     req_target_nxt = next_tbtt_r;
                     is_dtim_nxt    = (dtim_count_r == 8'd0);
                     req_nxt        = 1'b1;
                     state_nxt      = ST_REQ;
                  end else begin
                     state_nxt = ST_WAIT;
                  end
               end
            end
            ST_REQ: begin
               tbtt_ev_s = tbtt_hit_s;
               if (tx_ack) begin
                  req_nxt   = 1'b0;
                  state_nxt = ST_ACTIVE;
               end else if (late_s) begin
                  req_nxt    = 1'b0;
                  missed_nxt = sat_inc(missed_cnt_r);
                  state_nxt  = ST_WAIT;
               end else begin
                  state_nxt = ST_REQ;
               end
            end
            ST_ACTIVE: begin
               tbtt_ev_s = tbtt_hit_s;
               if (tx_done) begin
                  state_nxt = ST_WAIT;
               end else begin
                  state_nxt = ST_ACTIVE;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               req_nxt   = 1'b0;
            end
         endcase

         if (tbtt_ev_s) begin
            pulse_nxt      = 1'b1;
            next_tbtt_nxt  = next_tbtt_r + {{(TIMER_WIDTH-IW){1'b0}}, interval_r};
            dtim_count_nxt = (dtim_count_r == 8'd0) ? (dtim_period_r - 8'd1)
                                                    : (dtim_count_r - 8'd1);
         end else begin
            pulse_nxt = 1'b0;
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_r          <= ST_IDLE;
         cap_r            <= {TIMER_WIDTH{1'b0}};
         interval_r       <= {IW{1'b0}};
         dtim_period_r    <= 8'd1;
         next_tbtt_r      <= {TIMER_WIDTH{1'b0}};
         req_target_r     <= {TIMER_WIDTH{1'b0}};
         dtim_count_r     <= 8'd0;
         missed_cnt_r     <= {MISSED_WIDTH{1'b0}};
         beacon_req_r     <= 1'b0;
         beacon_is_dtim_r <= 1'b0;
         tbtt_pulse_r     <= 1'b0;
         div_start_r      <= 1'b0;
      end else begin
         state_r          <= state_nxt;
         cap_r            <= cap_nxt;
         interval_r       <= interval_nxt;
         dtim_period_r    <= dtim_period_nxt;
         next_tbtt_r      <= next_tbtt_nxt;
         req_target_r     <= req_target_nxt;
         dtim_count_r     <= dtim_count_nxt;
         missed_cnt_r     <= missed_nxt;
         beacon_req_r     <= req_nxt;
         beacon_is_dtim_r <= is_dtim_nxt;
         tbtt_pulse_r     <= pulse_nxt;
         div_start_r      <= div_start_nxt;
      end
   end

   assign beacon_req     = beacon_req_r;
   assign beacon_is_dtim = beacon_is_dtim_r;
   assign dtim_count     = dtim_count_r;
   assign next_tbtt      = next_tbtt_r;
   assign tbtt_pulse     = tbtt_pulse_r;
   assign missed_cnt     = missed_cnt_r;

endmodule

// File: tb/tb_beacon_tbtt_scheduler.sv
// Directed self-checking bench for beacon_tbtt_scheduler with hand-computed
// TBTT, DTIM and missed-beacon expectations.
module tb_beacon_tbtt_scheduler;

   logic        clk = 1'b0;
   logic        rstn;
   logic [63:0] tsf;
   logic        start_beaconing;
   logic [15:0] tu;
   logic [7:0]  dtim_period;
   logic [15:0] early;
   logic        tx_ack;
   logic        tx_done;
   logic        beacon_req;
   logic        beacon_is_dtim;
   logic [7:0]  dtim_count;
   logic [63:0] next_tbtt;
   logic        tbtt_pulse;
   logic [15:0] missed_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   beacon_tbtt_scheduler #(.TIMER_WIDTH(64), .TU_WIDTH(16)) dut (
      .clk                (clk),
      .rstn               (rstn),
      .tsf_runtime_val    (tsf),
      .start_beaconing    (start_beaconing),
      .beacon_interval_tu (tu),
      .dtim_period        (dtim_period),
      .early_us           (early),
      .tx_ack             (tx_ack),
      .tx_done            (tx_done),
      .beacon_req         (beacon_req),
      .beacon_is_dtim     (beacon_is_dtim),
      .dtim_count         (dtim_count),
      .next_tbtt          (next_tbtt),
      .tbtt_pulse         (tbtt_pulse),
      .missed_cnt         (missed_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_next(input logic [63:0] target, input int max_cyc,
                            output int cyc, output bit hit);
      hit = 1'b0;
      cyc = 0;
      while (!hit && cyc < max_cyc) begin
         step();
         cyc++;
         if (next_tbtt == target) hit = 1'b1;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; start_beaconing = 1'b0; tx_ack = 1'b0; tx_done = 1'b0;
      tsf = 64'd0; tu = 16'd0; early = 16'd0; dtim_period = 8'd0;
      step(); step();
      n_checks++; if (beacon_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0d expected 0", beacon_req); end
      n_checks++; if (beacon_is_dtim !== 1'b0) begin n_fail++; $display("FAIL reset_is_dtim: got %0d expected 0", beacon_is_dtim); end
      n_checks++; if (dtim_count !== 8'd0) begin n_fail++; $display("FAIL reset_dtim_count: got %0d expected 0", dtim_count); end
      n_checks++; if (next_tbtt !== 64'd0) begin n_fail++; $display("FAIL reset_next_tbtt: got %0d expected 0", next_tbtt); end
      n_checks++; if (tbtt_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %0d expected 0", tbtt_pulse); end
      n_checks++; if (missed_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_missed: got %0d expected 0", missed_cnt); end
      #3 rstn = 1'b1;
      repeat (3) step();
   endtask

   // 250000 mod 102400 = 45200 -> next_tbtt 307200, request at 305200
   task automatic test_align();
      tsf = 64'd250000; tu = 16'd100; dtim_period = 8'd3; early = 16'd2000;
      start_beaconing = 1'b1;
      repeat (66) step();
      n_checks++; if (next_tbtt !== 64'd0) begin n_fail++; $display("FAIL align_latency_early: got %0d expected 0", next_tbtt); end
      step();
      n_checks++; if (next_tbtt !== 64'd307200) begin n_fail++; $display("FAIL align_next_tbtt: got %0d expected 307200", next_tbtt); end
      n_checks++; if (dtim_count !== 8'd0) begin n_fail++; $display("FAIL align_dtim: got %0d expected 0", dtim_count); end
      tsf = 64'd305199; step();
      n_checks++; if (beacon_req !== 1'b0) begin n_fail++; $display("FAIL align_req_before: got %0d expected 0", beacon_req); end
      tsf = 64'd305200; step();
      n_checks++; if (beacon_req !== 1'b1) begin n_fail++; $display("FAIL align_req_rise: got %0d expected 1", beacon_req); end
      n_checks++; if (beacon_is_dtim !== 1'b1) begin n_fail++; $display("FAIL align_is_dtim: got %0d expected 1", beacon_is_dtim); end
      tx_ack = 1'b1; step(); tx_ack = 1'b0;
      n_checks++; if (beacon_req !== 1'b0) begin n_fail++; $display("FAIL align_req_ack: got %0d expected 0", beacon_req); end
      tsf = 64'd307199; step();
      n_checks++; if (tbtt_pulse !== 1'b0) begin n_fail++; $display("FAIL align_pulse_before: got %0d expected 0", tbtt_pulse); end
      tsf = 64'd307200; step();
      n_checks++; if (tbtt_pulse !== 1'b1) begin n_fail++; $display("FAIL align_pulse: got %0d expected 1", tbtt_pulse); end
      n_checks++; if (next_tbtt !== 64'd409600) begin n_fail++; $display("FAIL align_next_adv: got %0d expected 409600", next_tbtt); end
      n_checks++; if (dtim_count !== 8'd2) begin n_fail++; $display("FAIL align_dtim_adv: got %0d expected 2", dtim_count); end
      step();
      n_checks++; if (tbtt_pulse !== 1'b0) begin n_fail++; $display("FAIL align_pulse_single: got %0d expected 0", tbtt_pulse); end
      tx_done = 1'b1; step(); tx_done = 1'b0;
   endtask

   // Beacons 2..6 of the DTIM-3 sequence 1,0,0,1,0,0 / 0,2,1,0,2,1
   task automatic test_dtim();
      int  exp_cnt[5] = '{2, 1, 0, 2, 1};
      bit  exp_isd[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [63:0] t;
      for (int k = 1; k <= 5; k++) begin
         t = 64'd307200 + 64'(k) * 64'd102400;
         tsf = t - 64'd2000; step();
         n_checks++; if (beacon_req !== 1'b1) begin n_fail++; $display("FAIL dtim_req[%0d]: got %0d expected 1", k, beacon_req); end
         n_checks++; if (beacon_is_dtim !== exp_isd[k-1]) begin n_fail++; $display("FAIL dtim_is_dtim[%0d]: got %0d expected %0d", k, beacon_is_dtim, exp_isd[k-1]); end
         n_checks++; if (dtim_count !== 8'(exp_cnt[k-1])) begin n_fail++; $display("FAIL dtim_count[%0d]: got %0d expected %0d", k, dtim_count, exp_cnt[k-1]); end
         tx_ack = 1'b1; step(); tx_ack = 1'b0;
         tsf = t; step();
         n_checks++; if (tbtt_pulse !== 1'b1) begin n_fail++; $display("FAIL dtim_pulse[%0d]: got %0d expected 1", k, tbtt_pulse); end
         n_checks++; if (next_tbtt !== t + 64'd102400) begin n_fail++; $display("FAIL dtim_next[%0d]: got %0d expected %0d", k, next_tbtt, t + 64'd102400); end
         tx_done = 1'b1; step(); tx_done = 1'b0;
      end
   endtask

   // Request for TBTT 921600 never acknowledged; gives up at 1024000
   task automatic test_missed();
      tsf = 64'd919600; step();
      n_checks++; if (beacon_req !== 1'b1) begin n_fail++; $display("FAIL miss_req: got %0d expected 1", beacon_req); end
      n_checks++; if (beacon_is_dtim !== 1'b1) begin n_fail++; $display("FAIL miss_is_dtim: got %0d expected 1", beacon_is_dtim); end
      tsf = 64'd921600; step();
      n_checks++; if (tbtt_pulse !== 1'b1) begin n_fail++; $display("FAIL miss_pulse_in_req: got %0d expected 1", tbtt_pulse); end
      tsf = 64'd1023999; step();
      n_checks++; if (beacon_req !== 1'b1) begin n_fail++; $display("FAIL miss_req_held: got %0d expected 1", beacon_req); end
      tsf = 64'd1024000; step();
      n_checks++; if (beacon_req !== 1'b0) begin n_fail++; $display("FAIL miss_req_drop: got %0d expected 0", beacon_req); end
      n_checks++; if (missed_cnt !== 16'd1) begin n_fail++; $display("FAIL miss_cnt: got %0d expected 1", missed_cnt); end
      n_checks++; if (next_tbtt !== 64'd1126400) begin n_fail++; $display("FAIL miss_next: got %0d expected 1126400", next_tbtt); end
      tsf = 64'd1124400; step();
      n_checks++; if (beacon_req !== 1'b1) begin n_fail++; $display("FAIL miss_req_next: got %0d expected 1", beacon_req); end
      n_checks++; if (dtim_count !== 8'd1) begin n_fail++; $display("FAIL miss_dtim_next: got %0d expected 1", dtim_count); end
      n_checks++; if (beacon_is_dtim !== 1'b0) begin n_fail++; $display("FAIL miss_is_dtim_next: got %0d expected 0", beacon_is_dtim); end
      tx_ack = 1'b1; step(); tx_ack = 1'b0;
      tsf = 64'd1126400; step();
      tx_done = 1'b1; step(); tx_done = 1'b0;
   endtask

   task automatic test_jump();
      int cyc;
      bit hit;
      start_beaconing = 1'b0; step();
      tsf = 64'd300000; start_beaconing = 1'b1;
      wait_next(64'd307200, 100, cyc, hit);
      n_checks++; if (!hit) begin n_fail++; $display("FAIL jump_setup: next_tbtt %0d expected 307200 within 100 cycles", next_tbtt); end
      tsf = 64'd1000000; step();
      n_checks++; if (missed_cnt !== 16'd2) begin n_fail++; $display("FAIL jump_fwd_missed: got %0d expected 2", missed_cnt); end
      n_checks++; if (tbtt_pulse !== 1'b0) begin n_fail++; $display("FAIL jump_fwd_pulse: got %0d expected 0", tbtt_pulse); end
      wait_next(64'd1024000, 100, cyc, hit);
      n_checks++; if (!hit || cyc != 66) begin n_fail++; $display("FAIL jump_fwd_realign: next_tbtt %0d after %0d cycles, expected 1024000 after 66", next_tbtt, cyc); end
      tsf = 64'd10000; step();
      wait_next(64'd102400, 100, cyc, hit);
      n_checks++; if (!hit) begin n_fail++; $display("FAIL jump_bwd_realign: next_tbtt %0d expected 102400", next_tbtt); end
      n_checks++; if (missed_cnt !== 16'd2) begin n_fail++; $display("FAIL jump_bwd_missed: got %0d expected 2", missed_cnt); end
   endtask

   task automatic test_stop();
      int cyc;
      bit hit;
      start_beaconing = 1'b0; step();
      tsf = 64'd250000; start_beaconing = 1'b1;
      repeat (10) step();
      start_beaconing = 1'b0; step();
      n_checks++; if (beacon_req !== 1'b0) begin n_fail++; $display("FAIL stop_align_req: got %0d expected 0", beacon_req); end
      repeat (80) step();
      n_checks++; if (next_tbtt !== 64'd102400) begin n_fail++; $display("FAIL stop_align_next: got %0d expected 102400", next_tbtt); end
      start_beaconing = 1'b1;
      wait_next(64'd307200, 100, cyc, hit);
      n_checks++; if (!hit) begin n_fail++; $display("FAIL stop_restart: next_tbtt %0d expected 307200", next_tbtt); end
      tsf = 64'd305200; step();
      n_checks++; if (beacon_req !== 1'b1) begin n_fail++; $display("FAIL stop_req_up: got %0d expected 1", beacon_req); end
      start_beaconing = 1'b0; tx_ack = 1'b1; step(); tx_ack = 1'b0;
      n_checks++; if (beacon_req !== 1'b0) begin n_fail++; $display("FAIL stop_req_ack: got %0d expected 0", beacon_req); end
      tsf = 64'd307200; step();
      n_checks++; if (tbtt_pulse !== 1'b0) begin n_fail++; $display("FAIL stop_no_pulse: got %0d expected 0", tbtt_pulse); end
      n_checks++; if (next_tbtt !== 64'd307200) begin n_fail++; $display("FAIL stop_next_held: got %0d expected 307200", next_tbtt); end
      // 150000 mod 102400 = 47600 -> next_tbtt 204800
      tsf = 64'd150000; start_beaconing = 1'b1;
      wait_next(64'd204800, 100, cyc, hit);
      n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_setup: next_tbtt %0d expected 204800", next_tbtt); end
      tsf = 64'd203000; step();
      n_checks++; if (beacon_req !== 1'b1) begin n_fail++; $display("FAIL rst_req_up: got %0d expected 1", beacon_req); end
      #2 rstn = 1'b0;
      #1;
      n_checks++; if (beacon_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %0d expected 0", beacon_req); end
      n_checks++; if (beacon_is_dtim !== 1'b0) begin n_fail++; $display("FAIL rst_mid_is_dtim: got %0d expected 0", beacon_is_dtim); end
      n_checks++; if (next_tbtt !== 64'd0) begin n_fail++; $display("FAIL rst_mid_next: got %0d expected 0", next_tbtt); end
      n_checks++; if (missed_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_mid_missed: got %0d expected 0", missed_cnt); end
      start_beaconing = 1'b0;
      #2 rstn = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_zero_interval();
      bit seen_req = 1'b0;
      bit seen_pulse = 1'b0;
      tu = 16'd0; start_beaconing = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tsf = 64'(i) * 64'd5000;
         step();
         if (beacon_req) seen_req = 1'b1;
         if (tbtt_pulse) seen_pulse = 1'b1;
      end
      n_checks++; if (seen_req !== 1'b0) begin n_fail++; $display("FAIL zero_iv_req: got %0d expected 0", seen_req); end
      n_checks++; if (seen_pulse !== 1'b0) begin n_fail++; $display("FAIL zero_iv_pulse: got %0d expected 0", seen_pulse); end
      n_checks++; if (next_tbtt !== 64'd0) begin n_fail++; $display("FAIL zero_iv_next: got %0d expected 0", next_tbtt); end
   endtask

   initial begin
      test_reset();
      test_align();
      test_dtim();
      test_missed();
      test_jump();
      test_stop();
      test_zero_interval();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
